mux_nx1_scan: RTL

- Parametrised N-to-1 multiplexer with a registered output. Successor to the team's 2:1 mux primitives.
- Two modes: manual select, and an auto-scan mode in which an internal sequencer steps through every channel, holding each for a programmable dwell time.
- Sits between multi-channel sensor/data sources and a single-lane consumer; tags each output sample with its channel index and a valid strobe.

---
 rtl/mux_nx1_scan.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mux_nx1_scan.sv
// -----------------------------------------------------------------------------
// mux_nx1_scan
//
// N-to-1 multiplexer with a registered output and an optional auto-scan
// sequencer. In manual mode the channel comes from sel. In scan mode an
// internal index walks channels 0..N-1 and holds each one for DWELL enabled
// cycles. Every enabled sample is tagged with the channel it came from and a
// one-cycle valid strobe.
//
// Parameters
//   WIDTH  bits per channel
//   N      number of channels (>= 2)
//   SEL_W  select / index width, equal to clog2(N)
//   DWELL  enabled cycles each channel is held in scan mode (>= 1)
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   din      packed channel data, channel k at [k*WIDTH +: WIDTH]
//   sel      manual channel select (used only when mode = 0)
//   mode     0 = manual, 1 = auto-scan
//   en       sample enable; when low everything holds except y_valid/wrap,
//            which drop to 0
//   y        registered selected data
//   ch       channel index y was taken from
//   y_valid  high for the cycle following each enabled sample
//   wrap     high together with the last sample of channel N-1 in a scan,
//            i.e. on the edge where the scan index rolls back to 0
//   err      last manual sample used an out-of-range select (sel >= N)
// -----------------------------------------------------------------------------
module mux_nx1_scan #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SEL_W = 2,
    parameter int DWELL = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N*WIDTH-1:0]   din,
    input  logic [SEL_W-1:0]     sel,
    input  logic                 mode,
    input  logic                 en,
    output logic [WIDTH-1:0]     y,
    output logic [SEL_W-1:0]     ch,
    output logic                 y_valid,
    output logic                 wrap,
    output logic                 err
);

    // A DWELL of 1 still needs a one-bit counter so the compare stays legal.
    localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] IDX_LAST   = SEL_W'(N - 1);

    // Channel unpacking
    logic [WIDTH-1:0] w_chan [N];

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_chan
            assign w_chan[g] = din[g*WIDTH +: WIDTH];
        end
    endgenerate

    // Registered state
    logic [WIDTH-1:0] r_y;
    logic [SEL_W-1:0] r_ch;
    logic             r_valid;
    logic             r_wrap;
    logic             r_err;
    logic [SEL_W-1:0] r_idx;
    logic [DW_W-1:0]  r_dwell;

    // Selection paths
    logic [WIDTH-1:0] w_man_data;
    logic [WIDTH-1:0] w_scan_data;
    logic             w_sel_ok;
    logic             w_dwell_done;
    logic             w_idx_last;

    // Codes above N-1 only exist when N is not a power of two; such a
    // select decodes to no channel and the output is forced to zero.
    assign w_sel_ok     = (sel <= IDX_LAST);
    assign w_dwell_done = (r_dwell == DWELL_LAST);
    assign w_idx_last   = (r_idx == IDX_LAST);

    always_comb begin
        w_man_data = '0;
        for (int k = 0; k < N; k++) begin
            if (sel == SEL_W'(k)) begin
                w_man_data = w_chan[k];
            end
        end
    end

    always_comb begin
        w_scan_data = '0;
        for (int k = 0; k < N; k++) begin
            if (r_idx == SEL_W'(k)) begin
                w_scan_data = w_chan[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y     <= '0;
            r_ch    <= '0;
            r_valid <= 1'b0;
            r_wrap  <= 1'b0;
            r_err   <= 1'b0;
            r_idx   <= '0;
            r_dwell <= '0;
        end else if (en) begin
            r_valid <= 1'b1;
            if (!mode) begin
                // Manual: scan position parks at channel 0 / dwell 0 so that
                // entering scan always starts from the first channel.
                r_y     <= w_sel_ok ? w_man_data : '0;
                r_ch    <= sel;
                r_err   <= ~w_sel_ok;
                r_wrap  <= 1'b0;
                r_idx   <= '0;
                r_dwell <= '0;
            end else begin
                r_y   <= w_scan_data;
                r_ch  <= r_idx;
                r_err <= 1'b0;
                if (w_dwell_done) begin
                    r_dwell <= '0;
                    if (w_idx_last) begin
                        r_idx  <= '0;
                        r_wrap <= 1'b1;
                    end else begin
                        r_idx  <= r_idx + 1'b1;
                        r_wrap <= 1'b0;
                    end
                end else begin
                    r_dwell <= r_dwell + 1'b1;
                    r_wrap  <= 1'b0;
                end
            end
        end else begin
            // Paused: data, tag, error and scan position hold.
            r_valid <= 1'b0;
            r_wrap  <= 1'b0;
        end
    end

    assign y       = r_y;
    assign ch      = r_ch;
    assign y_valid = r_valid;
    assign wrap    = r_wrap;
    assign err     = r_err;

endmodule
